// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int DEF_MEM_BYTES = 64;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins outright, a tie goes
// to the port that was not served last.
module rr_pick2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // Pure combinational pick; no state of its own.
  always_comb begin
    valid  = |req;
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[1]) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of a 64-byte big-endian data memory.
// Each access: latch in IDLE, drive the memory for one ACCESS cycle, Ack in RESP.
// Optional build macro DATA_MEM_ARB_ALIGN_CHECK_EN: when defined, word
// addresses with Addr[1:0] != 0 are rejected as well as out-of-range ones.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic              CLK_in,
  input  logic              RST_in,
  input  logic              Req0_in,
  input  logic              Req1_in,
  input  logic              We0_in,
  input  logic              We1_in,
  input  logic [ADDR_W-1:0] Addr0_in,
  input  logic [ADDR_W-1:0] Addr1_in,
  input  logic [DATA_W-1:0] Wdata0_in,
  input  logic [DATA_W-1:0] Wdata1_in,
  output logic              Ack0_out,
  output logic              Ack1_out,
  output logic              Err0_out,
  output logic              Err1_out,
  output logic [DATA_W-1:0] Rdata_out,
  output logic [ADDR_W-1:0] Mem_Addr_out,
  output logic [DATA_W-1:0] Mem_Wdata_out,
  output logic              Mem_Read_en_out,
  output logic              Mem_Write_en_out,
  input  logic [DATA_W-1:0] Mem_Rdata_in
);

  // Highest address whose 4-byte word still fits; anything above it,
  // including addresses whose +3 wraps, lands outside the memory.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  arb_state_t        state_reg, state_next;
  logic              last_grant_reg;
  logic              port_reg;
  logic              we_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              pick_valid;
  logic              pick_winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_err;
  logic [1:0]        ack_vec;
  logic [1:0]        err_vec;

  rr_pick2 u_pick (
    .req        ({Req1_in, Req0_in}),
    .last_grant (last_grant_reg),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Select the winning port's request fields and classify the access.
  always_comb begin
    win_we    = pick_winner ? We1_in    : We0_in;
    win_addr  = pick_winner ? Addr1_in  : Addr0_in;
    win_wdata = pick_winner ? Wdata1_in : Wdata0_in;
`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
    win_err   = (win_addr > LAST_WORD) || (win_addr[1:0] != 2'b00);
`else
    win_err   = (win_addr > LAST_WORD);
`endif
  end

  // State register; reset asynchronously so the memory enables drop at once.
  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and memory-side outputs, which are live only in ACCESS.
  always_comb begin
    state_next       = state_reg;
    Mem_Addr_out     = '0;
    Mem_Wdata_out    = '0;
    Mem_Read_en_out  = 1'b0;
    Mem_Write_en_out = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) state_next = ACCESS;
      end
      ACCESS: begin
        Mem_Addr_out     = addr_reg;
        Mem_Wdata_out    = wdata_reg;
        Mem_Write_en_out = we_reg & ~err_reg;
        Mem_Read_en_out  = ~we_reg & ~err_reg;
        state_next       = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, read-data capture and round-robin history.
  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      last_grant_reg <= PORT_DBG;
      port_reg       <= PORT_CPU;
      we_reg         <= 1'b0;
      err_reg        <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
    end else begin
      if ((state_reg == IDLE) && pick_valid) begin
        port_reg  <= pick_winner;
        we_reg    <= win_we;
        addr_reg  <= win_addr;
        wdata_reg <= win_wdata;
        err_reg   <= win_err;
      end
      if (state_reg == ACCESS) begin
        rdata_reg <= (~we_reg & ~err_reg) ? Mem_Rdata_in : '0;
      end
      if (state_reg == RESP) begin
        last_grant_reg <= port_reg;
      end
    end
  end

  // Per-port completion: only the latched winner sees Ack/Err in RESP.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port_resp
    assign ack_vec[gi] = (state_reg == RESP) && (port_reg == 1'(gi));
    assign err_vec[gi] = ack_vec[gi] & err_reg;
  end

  assign Ack0_out  = ack_vec[0];
  assign Ack1_out  = ack_vec[1];
  assign Err0_out  = err_vec[0];
  assign Err1_out  = err_vec[1];
  assign Rdata_out = rdata_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter with a transaction-level
// reference model (byte-array memory image plus round-robin scheduling rules).
module tb_data_mem_arbiter;

  localparam int MB = 64;
`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .CLK_in           (clk),
    .RST_in           (rst),
    .Req0_in          (req0),
    .Req1_in          (req1),
    .We0_in           (we0),
    .We1_in           (we1),
    .Addr0_in         (addr0),
    .Addr1_in         (addr1),
    .Wdata0_in        (wdata0),
    .Wdata1_in        (wdata1),
    .Ack0_out         (ack0),
    .Ack1_out         (ack1),
    .Err0_out         (err0),
    .Err1_out         (err1),
    .Rdata_out        (rdata),
    .Mem_Addr_out     (mem_addr),
    .Mem_Wdata_out    (mem_wdata),
    .Mem_Read_en_out  (mem_re),
    .Mem_Write_en_out (mem_we),
    .Mem_Rdata_in     (mem_rdata)
  );

  // ---------------- external memory (environment) ----------------
  logic [7:0] mem     [MB];
  logic [7:0] ref_mem [MB];
  bit         mem_loaded = 1'b0;

  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MB; i++) mem[i] <= ref_mem[i];
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_addr <= 32'(MB - 1 - i))
          mem[6'(mem_addr[5:0] + 6'(i))] <= mem_wdata[31 - 8*i -: 8];
    end
  end

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (mem_addr <= 32'(MB - 1 - i))
        mem_rdata[31 - 8*i -: 8] = mem[6'(mem_addr[5:0] + 6'(i))];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } txn_t;

  txn_t        q0[$], q1[$];
  txn_t        cur[2];
  bit          active[2];
  int          wait_cnt[2];
  int          cyc = 0, next_free = 0, last_served = 1;
  bit          busy = 1'b0;
  int          acc_edge, acc_port;
  bit          acc_we, acc_err;
  logic [31:0] acc_addr, acc_wdata;
  logic [31:0] exp_rdata = '0;
  int          ack_cyc[2];
  int          gseq[$], gcyc[$];

  // A word access is legal only if all four bytes lie inside the memory.
  function automatic bit model_err(input logic [31:0] a);
    logic [63:0] last_byte;
    last_byte = {32'd0, a} + 64'd3;
    return (last_byte >= 64'(MB)) || (ALIGN_EN && (a % 4 != 0));
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v = {v[23:0], ref_mem[int'(a) + i]};
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = d[31 - 8*i -: 8];
  endtask

  task automatic push(input int p, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input int gap);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.gap = gap;
    if (p == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic advance_port(input int p);
    if (active[p]) return;
    if (p == 0 && q0.size() > 0) begin
      if (wait_cnt[0] < q0[0].gap) wait_cnt[0]++;
      else begin cur[0] = q0.pop_front(); active[0] = 1'b1; wait_cnt[0] = 0; end
    end else if (p == 1 && q1.size() > 0) begin
      if (wait_cnt[1] < q1[0].gap) wait_cnt[1]++;
      else begin cur[1] = q1.pop_front(); active[1] = 1'b1; wait_cnt[1] = 0; end
    end
  endtask

  task automatic drive();
    req0 = active[0]; we0 = cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].wdata;
    req1 = active[1]; we1 = cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].wdata;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ackerr"}, {28'd0, ack0, ack1, err0, err1}, 32'd0);
    check_eq({tag, "_en"}, {30'd0, mem_re, mem_we}, 32'd0);
    check_eq({tag, "_maddr"}, mem_addr, 32'd0);
    check_eq({tag, "_mwdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_rdata"}, rdata, 32'd0);
  endtask

  // One clock: predict grant at this edge, check outputs, then update drivers.
  task automatic step();
    logic [3:0]  e_ae;
    logic [1:0]  e_en;
    logic [31:0] e_a, e_d;
    @(posedge clk);
    cyc++;
    if (!busy && cyc >= next_free && (active[0] || active[1])) begin
      acc_port  = (active[0] && active[1]) ? (1 - last_served) : (active[1] ? 1 : 0);
      busy      = 1'b1;
      acc_edge  = cyc;
      acc_we    = cur[acc_port].we;
      acc_addr  = cur[acc_port].addr;
      acc_wdata = cur[acc_port].wdata;
      acc_err   = model_err(acc_addr);
      next_free = cyc + 3;
    end
    #1;
    e_ae = '0; e_en = '0; e_a = '0; e_d = '0;
    if (busy && cyc == acc_edge) begin
      e_a  = acc_addr;
      e_d  = acc_wdata;
      e_en = {!acc_we && !acc_err, acc_we && !acc_err};
    end
    if (busy && cyc == acc_edge + 1) begin
      exp_rdata = (!acc_we && !acc_err) ? ref_read(acc_addr) : 32'd0;
      e_ae = (acc_port == 0) ? {1'b1, 1'b0, acc_err, 1'b0} : {1'b0, 1'b1, 1'b0, acc_err};
    end
    check_eq("ack_err", {28'd0, ack0, ack1, err0, err1}, {28'd0, e_ae});
    check_eq("mem_en", {30'd0, mem_re, mem_we}, {30'd0, e_en});
    check_eq("mem_addr", mem_addr, e_a);
    check_eq("mem_wdata", mem_wdata, e_d);
    check_eq("rdata", rdata, exp_rdata);
    if (busy && cyc == acc_edge && acc_we && !acc_err) ref_write(acc_addr, acc_wdata);
    if (busy && cyc == acc_edge + 1) begin
      $display("txn cyc=%0d port=%0d %s addr=%h wdata=%h err=%0d rdata=%h",
               cyc, acc_port, acc_we ? "WR" : "RD", acc_addr, acc_wdata, acc_err, rdata);
      active[acc_port]  = 1'b0;
      ack_cyc[acc_port] = cyc;
      gseq.push_back(acc_port);
      gcyc.push_back(cyc);
      last_served = acc_port;
      busy = 1'b0;
    end
    advance_port(0);
    advance_port(1);
    drive();
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !active[0] && !active[1] && !busy)
           && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_drained"}, {31'd0, (n < budget)}, 32'd1);
  endtask

  // Start a write to 16, then hit reset inside its ACCESS cycle.
  task automatic reset_mid_write();
    repeat (2) step();
    cur[0].we = 1'b1; cur[0].addr = 32'd16; cur[0].wdata = 32'hCAFEF00D; cur[0].gap = 0;
    active[0] = 1'b1;
    drive();
    @(posedge clk);
    #2;
    check_eq("rst_pre_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    active[0] = 1'b0;
    drive();
    @(negedge clk);
    @(posedge clk);
    #1;
    check_idle_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    busy = 1'b0; next_free = 0; last_served = 1; exp_rdata = '0;
    check_eq("rst_mem16", {mem[16], mem[17], mem[18], mem[19]},
             {ref_mem[16], ref_mem[17], ref_mem[18], ref_mem[19]});
  endtask

  initial begin
    logic [31:0] a;
    int          p, sel;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      cur[i].we = 1'b0; cur[i].addr = '0; cur[i].wdata = '0; cur[i].gap = 0;
      active[i] = 1'b0; wait_cnt[i] = 0; ack_cyc[i] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Write 0xDEADBEEF to 8, read it back; then port 1 reads 60
    push(0, 1'b1, 32'd8, 32'hDEADBEEF, 0);
    push(0, 1'b0, 32'd8, 32'd0, 1);
    run_drain("wr_rd8", 100);
    push(1, 1'b0, 32'd60, 32'd0, 0);
    run_drain("rd60", 100);

    // Tie on first contention after port 1 was last: port 0 first, 3 cycles apart
    push(0, 1'b0, 32'd0, 32'd0, 0);
    push(1, 1'b0, 32'd4, 32'd0, 0);
    run_drain("tie", 100);
    check_eq("tie_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);

    // Out-of-range reads on port 1
    push(1, 1'b0, 32'd61, 32'd0, 0);
    push(1, 1'b0, 32'hFFFFFFFE, 32'd0, 0);
    run_drain("range", 100);

    // Unaligned write to 2 and read-back
    push(0, 1'b1, 32'd2, 32'h11223344, 0);
    push(0, 1'b0, 32'd2, 32'd0, 0);
    run_drain("unal", 100);
    if (ALIGN_EN)
      check_eq("unal_bytes", {mem[2], mem[3], mem[4], mem[5]},
               {ref_mem[2], ref_mem[3], ref_mem[4], ref_mem[5]});
    else
      check_eq("unal_bytes", {mem[2], mem[3], mem[4], mem[5]}, 32'h11223344);

    // Both ports saturate: six grants must alternate, 3 cycles apart
    gseq.delete();
    gcyc.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom, 0);
      push(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom, 0);
    end
    run_drain("sat", 200);
    check_eq("sat_count", 32'(gseq.size()), 32'd6);
    for (int i = 1; i < gseq.size(); i++) begin
      check_eq("sat_alt", 32'(gseq[i]), 32'(1 - gseq[i-1]));
      check_eq("sat_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end

    // Random traffic
    repeat (40) begin
      p   = $urandom_range(0, 1);
      sel = $urandom_range(0, 7);
      if (sel <= 4)      a = 32'($urandom_range(0, 15) * 4);
      else if (sel == 5) a = 32'($urandom_range(0, 63));
      else if (sel == 6) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else               a = $urandom;
      push(p, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end
    run_drain("rand", 2000);

    // Reset during an ACCESS write, then confirm address 16 untouched
    reset_mid_write();
    repeat (4) step();
    push(1, 1'b0, 32'd16, 32'd0, 0);
    run_drain("post_rst", 100);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-port, byte-addressed, big-endian data memory (64 bytes, combinational read, write on falling clock edge). Port 0 serves the CPU load/store path; port 1 serves the program loader/debug path. The block latches one request, drives the memory for exactly one cycle, returns the read data and an error flag with a one-cycle acknowledge, and alternates priority round-robin.

## Interface
- ADDR_W, 32, address width of both requesters and the memory side
- DATA_W, 32, data word width
- MEM_BYTES, 64, memory size in bytes; the last legal word address is MEM_BYTES-4
- CLK_in  in  1  system clock; all state updates on rising edge
- RST_in  in  1  reset, asynchronous, active-high
- Req0_in / Req1_in  in  1  access request; held high until the matching Ack
- We0_in / We1_in  in  1  1 = write, 0 = read; valid while Req is high
- Addr0_in / Addr1_in  in  ADDR_W  byte address of the word's MSB byte
- Wdata0_in / Wdata1_in  in  DATA_W  write data
- Ack0_out / Ack1_out  out  1  one-cycle completion pulse
- Err0_out / Err1_out  out  1  valid with Ack; 1 = access rejected
- Rdata_out  out  DATA_W  read data, shared by both ports; valid with either Ack
- Mem_Addr_out  out  ADDR_W  memory address
- Mem_Wdata_out  out  DATA_W  memory write data
- Mem_Read_en_out / Mem_Write_en_out  out  1  memory enables
- Mem_Rdata_in  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: if any Req is high, pick a winner, latch its We, Addr and Wdata and its port index, evaluate the error check, then go to ACCESS. If no Req is high, stay in IDLE.
- Arbitration: a single requester wins outright. When both request, the winner is the port not served last. The last_grant register resets to 1, so port 0 wins the first tie.
- ACCESS: Mem_Addr and Mem_Wdata come from the latches. Write_en = We & ~err and Read_en = ~We & ~err, both for this cycle only. The memory commits a write at the falling edge inside ACCESS. At the rising edge, Rdata is captured: Mem_Rdata for a good read, otherwise 0. Then go to RESP.
- RESP: the winner's Ack is 1 and its Err equals the latched err. Update last_grant, then go to IDLE.
- Error check: Addr > MEM_BYTES-4 is an error, including wrap-around (Addr+3 overflowing ADDR_W). An error suppresses both memory enables and returns Rdata 0.
- Outside ACCESS: Mem_Addr, Mem_Wdata and both enables are 0.
- The losing request stays pending and is served after the winner's RESP. No request is dropped.
- A Req that drops before its Ack is a protocol violation. The latched access still completes.

## Timing
- Req sampled high at edge k → ACCESS in cycle k+1 → Ack in cycle k+2 → IDLE in cycle k+3. Minimum 3 cycles per access.
- A requester that keeps Req high after Ack is treated as issuing a new request, sampled at the IDLE edge.
- Back-to-back both-port traffic alternates 0,1,0,1.
- Reset values: every output is 0, state is IDLE, last_grant is 1, Rdata register is 0.
- Reset mid-ACCESS: enables drop immediately (asynchronous), so no write commits at the following falling edge. The pending access is lost and no Ack is issued.

## Configuration
- DATA_MEM_ARB_ALIGN_CHECK_EN
- Defined: Addr[1:0] != 0 is also an error, with the same Err/suppression behaviour as an out-of-range address.
- Undefined: unaligned addresses are legal, and the memory performs a big-endian byte-granular word access. Only the range check applies.

## Structure
- Package data_mem_arb_pkg holds:
  - the state enum {IDLE, ACCESS, RESP}
  - port index constants PORT_CPU=0 and PORT_DBG=1
  - the default MEM_BYTES
- One sub-module, rr_pick2: combinational two-way round-robin chooser. Inputs req[1:0] and last_grant; outputs valid and winner.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to address 8 → Mem_Write_en high for one cycle. A later read of address 8 returns 0xDEADBEEF with Ack0 in cycle k+2 and Err0=0.
- Both ports request reads in the same cycle (addresses 0 and 4) → port 0 is served first, then port 1, with Ack0 three cycles before Ack1.
- Port 1 reads address 60 → OK. Port 1 reads addresses 61 and 0xFFFFFFFE → Err1=1, Rdata 0, no memory enable asserted.
- Port 0 writes to address 2 → with the macro: Err0=1 and no write. Without the macro: bytes 2..5 take 0x11223344 in big-endian order.
- RST_in asserted in the middle of an ACCESS write to address 16 → memory at 16 is unchanged, no Ack, all outputs 0.
- Both ports hold Req for six accesses → grants alternate 0,1,0,1,0,1 and the Ack spacing is exactly 3 cycles.
